dpd_adapt_seq: RTL and testbench

- Sequences DPD adaptation on the PA feedback path and aligns that feedback to the DPD input before it reaches the dpd block's sig_pa_i/q.
- Contains a circular-buffer feedback delay with run-time programmable delay and a saturating power-of-two gain.
- Contains an FSM that generates repeated dpd_adapt windows with programmable settle time, window length, gap and iteration count.
- Sits between the PA feedback ADC path and dpd; one instance per transmit chain.

---
 rtl/dpd_adapt_seq.sv | 209 ++++++++++++++++++++
 tb/tb_dpd_adapt_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dpd_adapt_seq.sv
// DPD adaptation sequencer: aligns PA feedback to the DPD input through a programmable
// circular-buffer delay with saturating power-of-two gain, and generates dpd_adapt windows.
module dpd_adapt_seq #(
    parameter int unsigned W         = 20,
    parameter int unsigned MAX_DELAY = 1024,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned ITER_W    = 16
) (
    input  logic                          clk,
    input  logic                          reset_b,
    input  logic                          start,
    input  logic                          stop,
    input  logic [CNT_W-1:0]              cfg_wait,
    input  logic [CNT_W-1:0]              cfg_len,
    input  logic [CNT_W-1:0]              cfg_gap,
    input  logic [ITER_W-1:0]             cfg_num_iter,
    input  logic [$clog2(MAX_DELAY)-1:0]  cfg_delay,
    input  logic [2:0]                    cfg_shift,
    input  logic signed [W-1:0]           fb_in_i,
    input  logic signed [W-1:0]           fb_in_q,
    output logic signed [W-1:0]           fb_out_i,
    output logic signed [W-1:0]           fb_out_q,
    output logic                          fb_valid,
    output logic                          dpd_adapt,
    output logic                          busy,
    output logic [ITER_W-1:0]             iter_cnt,
    output logic                          done
);

    localparam int unsigned AW = $clog2(MAX_DELAY);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ADAPT, S_GAP, S_DONE} state_e;

    // Left shift by 0..7 with clamping to the signed W-bit range.
    function automatic logic [W-1:0] sat_shl(input logic [W-1:0] x, input logic [2:0] sh);
        logic [W+6:0] wide;
        logic [7:0]   top;
        wide = {{7{x[W-1]}}, x} << sh;
        top  = wide[W+6:W-1];
        if (top == '0 || top == '1) begin
            sat_shl = wide[W-1:0];
        end else if (wide[W+6]) begin
            sat_shl = {1'b1, {(W-1){1'b0}}};
        end else begin
            sat_shl = {1'b0, {(W-1){1'b1}}};
        end
    endfunction

    logic [2*W-1:0] buf_mem [MAX_DELAY];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] delay_q, delay_d;
    logic [AW:0]   fill_q, fill_d;
    logic          fb_valid_q, fb_valid_d;
    logic [W-1:0]  fb_i_q, fb_i_d, fb_q_q, fb_q_d;
    logic [AW-1:0] rd_addr;
    logic [2*W-1:0] rd_word;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  wait_q, wait_d, len_q, len_d, gap_q, gap_d;
    logic [ITER_W-1:0] num_q, num_d, iter_q, iter_d, iter_inc;
    logic              last_win;
    logic              adapt_q, adapt_d, busy_q, busy_d, done_q, done_d;

    always_ff @(posedge clk) begin
        buf_mem[wr_ptr_q] <= {fb_in_q, fb_in_i};
    end

    // Delay 0 bypasses the buffer, since that slot is being overwritten this cycle.
    always_comb begin
        rd_addr  = wr_ptr_q - cfg_delay;
        rd_word  = (cfg_delay == '0) ? {fb_in_q, fb_in_i} : buf_mem[rd_addr];
        wr_ptr_d = wr_ptr_q + AW'(1);
        delay_d  = cfg_delay;
        if (cfg_delay != delay_q) begin
            fill_d     = (AW+1)'(1);
            fb_valid_d = 1'b0;
        end else begin
            fill_d     = (fill_q == (AW+1)'(MAX_DELAY)) ? fill_q : fill_q + (AW+1)'(1);
            fb_valid_d = (fill_q >= {1'b0, cfg_delay});
        end
        fb_i_d = fb_valid_d ? sat_shl(rd_word[W-1:0], cfg_shift) : '0;
        fb_q_d = fb_valid_d ? sat_shl(rd_word[2*W-1:W], cfg_shift) : '0;
    end

    // Window sequencer; stop has priority over everything, loss of alignment over timing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        iter_d   = iter_q;
        wait_d   = wait_q;
        len_d    = len_q;
        gap_d    = gap_q;
        num_d    = num_q;
        iter_inc = (iter_q == '1) ? iter_q : iter_q + ITER_W'(1);
        last_win = (num_q != '0) && (iter_inc >= num_q);
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                        iter_d  = '0;
                        wait_d  = cfg_wait;
                        len_d   = cfg_len;
                        gap_d   = cfg_gap;
                        num_d   = cfg_num_iter;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q >= wait_q && fb_valid_q) begin
                        cnt_d = '0;
                        if (len_q == '0) begin
                            iter_d  = iter_inc;
                            state_d = last_win ? S_DONE : S_GAP;
                        end else begin
                            state_d = S_ADAPT;
                        end
                    end else if (cnt_q < wait_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_ADAPT: begin
                    if (!fb_valid_q) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == len_q - CNT_W'(1)) begin
                        cnt_d   = '0;
                        iter_d  = iter_inc;
                        state_d = last_win ? S_DONE : S_GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (!fb_valid_q) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else if (gap_q == '0 || cnt_q == gap_q - CNT_W'(1)) begin
                        cnt_d = '0;
                        if (len_q == '0) begin
                            iter_d  = iter_inc;
                            state_d = last_win ? S_DONE : S_GAP;
                        end else begin
                            state_d = S_ADAPT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        adapt_d = (state_d == S_ADAPT);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr_q   <= '0;
            delay_q    <= '0;
            fill_q     <= '0;
            fb_valid_q <= 1'b0;
            fb_i_q     <= '0;
            fb_q_q     <= '0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wait_q     <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            num_q      <= '0;
            iter_q     <= '0;
            adapt_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            delay_q    <= delay_d;
            fill_q     <= fill_d;
            fb_valid_q <= fb_valid_d;
            fb_i_q     <= fb_i_d;
            fb_q_q     <= fb_q_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            num_q      <= num_d;
            iter_q     <= iter_d;
            adapt_q    <= adapt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fb_out_i  = fb_i_q;
    assign fb_out_q  = fb_q_q;
    assign fb_valid  = fb_valid_q;
    assign dpd_adapt = adapt_q;
    assign busy      = busy_q;
    assign iter_cnt  = iter_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dpd_adapt_seq.sv
// Directed bench for dpd_adapt_seq: delay/gain path, window timing, abort and reset paths.
module tb_dpd_adapt_seq;

    localparam int unsigned W         = 20;
    localparam int unsigned MAX_DELAY = 1024;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned ITER_W    = 16;

    logic                         clk;
    logic                         reset_b;
    logic                         start;
    logic                         stop;
    logic [CNT_W-1:0]             cfg_wait;
    logic [CNT_W-1:0]             cfg_len;
    logic [CNT_W-1:0]             cfg_gap;
    logic [ITER_W-1:0]            cfg_num_iter;
    logic [$clog2(MAX_DELAY)-1:0] cfg_delay;
    logic [2:0]                   cfg_shift;
    logic signed [W-1:0]          fb_in_i;
    logic signed [W-1:0]          fb_in_q;
    logic signed [W-1:0]          fb_out_i;
    logic signed [W-1:0]          fb_out_q;
    logic                         fb_valid;
    logic                         dpd_adapt;
    logic                         busy;
    logic [ITER_W-1:0]            iter_cnt;
    logic                         done;

    int n_vec;
    int n_miss;
    int cyc;

    dpd_adapt_seq #(
        .W(W), .MAX_DELAY(MAX_DELAY), .CNT_W(CNT_W), .ITER_W(ITER_W)
    ) dut (
        .clk(clk), .reset_b(reset_b), .start(start), .stop(stop),
        .cfg_wait(cfg_wait), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
        .cfg_num_iter(cfg_num_iter), .cfg_delay(cfg_delay), .cfg_shift(cfg_shift),
        .fb_in_i(fb_in_i), .fb_in_q(fb_in_q), .fb_out_i(fb_out_i), .fb_out_q(fb_out_q),
        .fb_valid(fb_valid), .dpd_adapt(dpd_adapt), .busy(busy),
        .iter_cnt(iter_cnt), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Cycle n is the interval before edge n; inputs set in it are sampled at edge n.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int s;
        int hi;
        int done_n;
        int n;
        int r;
        logic exp_a;

        n_vec = 0; n_miss = 0; cyc = 0;
        reset_b = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_wait = '0; cfg_len = '0; cfg_gap = '0; cfg_num_iter = '0;
        cfg_delay = 10'd500; cfg_shift = 3'd3;
        fb_in_i = '0; fb_in_q = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_fb_out_i", 32'(fb_out_i), 32'd0);
        check("rst_fb_valid", 32'(fb_valid), 32'd0);
        check("rst_adapt",    32'(dpd_adapt), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_iter",     32'(iter_cnt), 32'd0);
        check("rst_done",     32'(done), 32'd0);
        reset_b = 1'b1;
        cyc = 0;

        // Impulse and saturation through a 500-sample delay, gain x8.
        while (cyc < 1030) begin
            fb_in_i = '0;
            fb_in_q = '0;
            if (cyc == 10) fb_in_i = 20'sd1000;
            if (cyc == 520) begin fb_in_i = 20'sd100000;  fb_in_q = -20'sd3;    end
            if (cyc == 521) begin fb_in_i = -20'sd100000; fb_in_q = 20'sd65535; end
            step();
            if (cyc == 500) check("valid_pre", 32'(fb_valid), 32'd0);
            if (cyc == 501) check("valid_rise", 32'(fb_valid), 32'd1);
            if (cyc == 510) check("imp_before", 32'(fb_out_i), 32'd0);
            if (cyc == 511) check("imp_out", 32'(fb_out_i), 32'd8000);
            if (cyc == 512) check("imp_after", 32'(fb_out_i), 32'd0);
            if (cyc == 1021) begin
                check("sat_pos", 32'(fb_out_i), 32'(524287));
                check("q_neg",   32'(fb_out_q), 32'(-24));
            end
            if (cyc == 1022) begin
                check("sat_neg", 32'(fb_out_i), 32'(-524288));
                check("q_big",   32'(fb_out_q), 32'(524280));
            end
        end

        // Single long window; a start mid-run must be ignored.
        cfg_wait = 1000; cfg_len = 801; cfg_gap = 0; cfg_num_iter = 1;
        start = 1'b1; s = cyc;
        step();
        start = 1'b0;
        check("w1_busy", 32'(busy), 32'd1);
        check("w1_idle_adapt", 32'(dpd_adapt), 32'd0);
        hi = 0; done_n = 0;
        while (cyc < s + 1810) begin
            if (cyc == s + 500) begin start = 1'b1; cfg_wait = 0; cfg_len = 3; end
            else start = 1'b0;
            step();
            hi += int'(dpd_adapt);
            done_n += int'(done);
            if (cyc == s + 1001) check("w1_pre", 32'(dpd_adapt), 32'd0);
            if (cyc == s + 1002) check("w1_first", 32'(dpd_adapt), 32'd1);
            if (cyc == s + 1802) check("w1_last", 32'(dpd_adapt), 32'd1);
            if (cyc == s + 1803) begin
                check("w1_post", 32'(dpd_adapt), 32'd0);
                check("w1_done", 32'(done), 32'd1);
                check("w1_iter", 32'(iter_cnt), 32'd1);
            end
            if (cyc == s + 1804) begin
                check("w1_idle", 32'(busy), 32'd0);
                check("w1_done_pulse", 32'(done), 32'd0);
            end
        end
        check("w1_len", 32'(hi), 32'd801);
        check("w1_done_cnt", 32'(done_n), 32'd1);

        // start and stop together in IDLE: stop wins.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("ss_busy", 32'(busy), 32'd0);
        step();
        check("ss_busy2", 32'(busy), 32'd0);
        check("ss_iter_hold", 32'(iter_cnt), 32'd1);

        // Three back-to-back 10-cycle windows with zero gap.
        cfg_wait = 0; cfg_len = 10; cfg_gap = 0; cfg_num_iter = 3;
        start = 1'b1; s = cyc;
        step();
        start = 1'b0;
        check("w3_iter_clr", 32'(iter_cnt), 32'd0);
        done_n = 0;
        while (cyc < s + 40) begin
            step();
            n = cyc - s;
            exp_a = (n >= 2 && n <= 11) || (n >= 13 && n <= 22) || (n >= 24 && n <= 33);
            check("w3_adapt", 32'(dpd_adapt), 32'(exp_a));
            done_n += int'(done);
            if (n == 12) check("w3_iter1", 32'(iter_cnt), 32'd1);
            if (n == 23) check("w3_iter2", 32'(iter_cnt), 32'd2);
            if (n == 34) begin
                check("w3_iter3", 32'(iter_cnt), 32'd3);
                check("w3_done", 32'(done), 32'd1);
            end
        end
        check("w3_done_cnt", 32'(done_n), 32'd1);

        // Continuous run; delay change mid-window, then stop.
        cfg_wait = 3; cfg_len = 20; cfg_gap = 5; cfg_num_iter = 0;
        fb_in_i = 20'sd7;
        start = 1'b1; s = cyc;
        step();
        start = 1'b0;
        done_n = 0;
        while (cyc < s + 12) begin
            if (cyc == s + 10) cfg_delay = 10'd20;
            step();
            done_n += int'(done);
            if (cyc == s + 4) check("c_pre", 32'(dpd_adapt), 32'd0);
            if (cyc == s + 5) check("c_first", 32'(dpd_adapt), 32'd1);
            if (cyc == s + 11) begin
                check("c_valid_drop", 32'(fb_valid), 32'd0);
                check("c_out_gated", 32'(fb_out_i), 32'd0);
                check("c_adapt_hold", 32'(dpd_adapt), 32'd1);
            end
        end
        check("c_adapt_drop", 32'(dpd_adapt), 32'd0);
        check("c_busy", 32'(busy), 32'd1);
        check("c_iter_kept", 32'(iter_cnt), 32'd0);
        n = 0;
        while (dpd_adapt !== 1'b1 && n < 200) begin
            step();
            done_n += int'(done);
            n++;
        end
        check("c_resume", 32'(dpd_adapt), 32'd1);
        check("c_resume_valid", 32'(fb_valid), 32'd1);
        check("c_resume_out", 32'(fb_out_i), 32'd56);
        check("c_resume_iter", 32'(iter_cnt), 32'd0);
        r = cyc;
        while (cyc < r + 22) begin
            step();
            done_n += int'(done);
        end
        check("c_iter1", 32'(iter_cnt), 32'd1);
        check("c_gap", 32'(dpd_adapt), 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        done_n += int'(done);
        check("c_stop_busy", 32'(busy), 32'd0);
        check("c_stop_adapt", 32'(dpd_adapt), 32'd0);
        repeat (5) begin
            step();
            done_n += int'(done);
        end
        check("c_no_done", 32'(done_n), 32'd0);
        check("c_iter_hold", 32'(iter_cnt), 32'd1);

        // Asynchronous reset in the middle of a window.
        cfg_wait = 0; cfg_len = 50; cfg_num_iter = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check("r_adapt_pre", 32'(dpd_adapt), 32'd1);
        #2;
        reset_b = 1'b0;
        #1;
        check("r_adapt",    32'(dpd_adapt), 32'd0);
        check("r_busy",     32'(busy), 32'd0);
        check("r_valid",    32'(fb_valid), 32'd0);
        check("r_fb_out_i", 32'(fb_out_i), 32'd0);
        check("r_iter",     32'(iter_cnt), 32'd0);
        check("r_done",     32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
